// File: rtl/uart_rx_fifo_if.sv
// Receive-side FIFO bus: receiver strobes in, register-interface controls,
// occupancy and error status out. master drives, slave is the FIFO.
interface uart_rx_fifo_if #(
   parameter int DATA_BITS = 8,
   parameter int DEPTH     = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                 rx_done;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_error_in;
   logic                 s_tick;
   logic                 rd_en;
   logic                 flush;
   logic                 ovr_clr;
   logic                 ferr_clr;
   logic [DATA_BITS-1:0] rd_data;
   logic                 empty;
   logic                 full;
   logic [CW-1:0]        count;
   logic                 overrun;
   logic                 frame_err;
   logic                 rx_timeout;

   modport master (
      output rx_done, rx_data, rx_error_in, s_tick,
      output rd_en, flush, ovr_clr, ferr_clr,
      input  rd_data, empty, full, count,
      input  overrun, frame_err, rx_timeout
   );

   modport slave (
      input  rx_done, rx_data, rx_error_in, s_tick,
      input  rd_en, flush, ovr_clr, ferr_clr,
      output rd_data, empty, full, count,
      output overrun, frame_err, rx_timeout
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO, first-word-fall-through, with sticky error flags.
// Optional character timeout built when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
   parameter int DATA_BITS     = 8,
   parameter int DEPTH         = 16,
   parameter int TIMEOUT_TICKS = 64
) (
   input  logic           clk,
   input  logic           PRESETn,
   uart_rx_fifo_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 overrun_q, overrun_d;
   logic                 ferr_q, ferr_d;
   logic                 err_hist_q, err_hist_d;
   logic                 empty, full;
   logic                 do_push, do_pop;
   logic                 ovr_set, ferr_set;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   // Push/pop qualification; flush wins over both
   always_comb begin
      do_pop   = bus.rd_en && !empty && !bus.flush;
      do_push  = bus.rx_done && !bus.flush
                 && (!full || (bus.rd_en && !empty));
      ovr_set  = bus.rx_done && full && !bus.rd_en;
      ferr_set = bus.rx_error_in && !err_hist_q;
   end

   // Next-state for pointers, occupancy and sticky flags
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      err_hist_d = bus.rx_error_in;
      overrun_d  = ovr_set || (overrun_q && !bus.ovr_clr);
      ferr_d     = ferr_set || (ferr_q && !bus.ferr_clr);
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push && !do_pop)
            count_d = count_q + CW'(1);
         else if (do_pop && !do_push)
            count_d = count_q - CW'(1);
      end
   end

   // Control state register
   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overrun_q  <= 1'b0;
         ferr_q     <= 1'b0;
         err_hist_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overrun_q  <= overrun_d;
         ferr_q     <= ferr_d;
         err_hist_q <= err_hist_d;
      end
   end

   // Character storage; contents deliberately not reset
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= bus.rx_data;
   end

`ifdef UART_RX_FIFO_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);

   logic [TW-1:0] tmo_q, tmo_d;

   // Idle counter: restarts on any traffic, saturates at the limit
   always_comb begin
      tmo_d = tmo_q;
      if (do_push || do_pop || bus.flush || empty)
         tmo_d = '0;
      else if (bus.s_tick && tmo_q != TW'(TIMEOUT_TICKS))
         tmo_d = tmo_q + TW'(1);
   end

   // Timeout counter register
   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) tmo_q <= '0;
      else          tmo_q <= tmo_d;
   end

   assign bus.rx_timeout = (tmo_q == TW'(TIMEOUT_TICKS));
`else
   assign bus.rx_timeout = 1'b0;
`endif

   assign bus.rd_data   = mem_q[rd_ptr_q];
   assign bus.empty     = empty;
   assign bus.full      = full;
   assign bus.count     = count_q;
   assign bus.overrun   = overrun_q;
   assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected characters,
// a negedge monitor checks each popped head against the queue.
module tb_uart_rx_fifo;
   logic clk = 1'b0;
   logic PRESETn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] sb [$];

   uart_rx_fifo_if #(.DATA_BITS(8), .DEPTH(16)) ifc ();

   uart_rx_fifo #(
      .DATA_BITS(8), .DEPTH(16), .TIMEOUT_TICKS(64)
   ) dut (
      .clk(clk),
      .PRESETn(PRESETn),
      .bus(ifc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: a qualified pop shows the head on rd_data
   always @(negedge clk) begin
      if (PRESETn && ifc.rd_en && !ifc.empty && !ifc.flush) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_data: got %0h expected none", ifc.rd_data);
         end else begin
            chk("pop_data", 32'(ifc.rd_data), 32'(sb.pop_front()));
         end
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] d, input bit acc);
      ifc.rx_done = 1'b1;
      ifc.rx_data = d;
      if (acc) sb.push_back(d);
      cyc();
      ifc.rx_done = 1'b0;
   endtask

   task automatic pop(input int n = 1);
      ifc.rd_en = 1'b1;
      cyc(n);
      ifc.rd_en = 1'b0;
   endtask

   initial begin
      ifc.rx_done = 0; ifc.rx_data = '0; ifc.rx_error_in = 0;
      ifc.s_tick = 0; ifc.rd_en = 0; ifc.flush = 0;
      ifc.ovr_clr = 0; ifc.ferr_clr = 0;
      cyc(3);
      chk("rst_empty", 32'(ifc.empty), 1);
      chk("rst_full", 32'(ifc.full), 0);
      chk("rst_count", 32'(ifc.count), 0);
      chk("rst_ovr", 32'(ifc.overrun), 0);
      chk("rst_ferr", 32'(ifc.frame_err), 0);
      chk("rst_tmo", 32'(ifc.rx_timeout), 0);
      PRESETn = 1'b1;
      cyc();

      // Basic ordering
      push(8'h41, 1); push(8'h42, 1); push(8'h43, 1);
      chk("b_count", 32'(ifc.count), 3);
      chk("b_head", 32'(ifc.rd_data), 32'h41);
      pop(3);
      chk("b_empty", 32'(ifc.empty), 1);
      pop();
      chk("pop_empty_cnt", 32'(ifc.count), 0);

      // Overflow
      for (int i = 0; i < 16; i++) push(8'(i), 1);
      push(8'h10, 0);
      chk("o_full", 32'(ifc.full), 1);
      chk("o_count", 32'(ifc.count), 16);
      chk("o_ovr", 32'(ifc.overrun), 1);
      pop(16);
      chk("o_empty", 32'(ifc.empty), 1);
      chk("o_ovr_hold", 32'(ifc.overrun), 1);
      ifc.ovr_clr = 1; cyc(); ifc.ovr_clr = 0;
      chk("o_ovr_clr", 32'(ifc.overrun), 0);

      // Full with simultaneous push and pop
      for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1);
      ifc.rx_done = 1; ifc.rx_data = 8'hAA; ifc.rd_en = 1;
      sb.push_back(8'hAA);
      cyc();
      ifc.rx_done = 0; ifc.rd_en = 0;
      chk("f_count", 32'(ifc.count), 16);
      chk("f_ovr", 32'(ifc.overrun), 0);
      pop(15);
      chk("f_last", 32'(ifc.rd_data), 32'hAA);
      pop();
      chk("f_empty", 32'(ifc.empty), 1);

      // Push and pop together while empty
      ifc.rx_done = 1; ifc.rx_data = 8'h55; ifc.rd_en = 1;
      sb.push_back(8'h55);
      cyc();
      ifc.rx_done = 0; ifc.rd_en = 0;
      chk("e_count", 32'(ifc.count), 1);
      pop();

      // Frame error edge detect, set beats clear
      ifc.rx_error_in = 1; ifc.ferr_clr = 1; cyc();
      ifc.ferr_clr = 0;
      chk("fe_set", 32'(ifc.frame_err), 1);
      ifc.ferr_clr = 1; cyc(); ifc.ferr_clr = 0;
      chk("fe_clr", 32'(ifc.frame_err), 0);
      cyc(3);
      chk("fe_noreset", 32'(ifc.frame_err), 0);
      ifc.rx_error_in = 0; cyc();
      ifc.rx_error_in = 1; cyc();
      ifc.rx_error_in = 0;

      // Flush overrides push, keeps flags
      for (int i = 0; i < 5; i++) push(8'(8'h60 + i), 1);
      ifc.flush = 1; ifc.rx_done = 1; ifc.rx_data = 8'h77;
      cyc();
      ifc.flush = 0; ifc.rx_done = 0;
      sb.delete();
      chk("fl_count", 32'(ifc.count), 0);
      chk("fl_empty", 32'(ifc.empty), 1);
      chk("fl_ferr", 32'(ifc.frame_err), 1);
      ifc.ferr_clr = 1; cyc(); ifc.ferr_clr = 0;

      // Character timeout
      push(8'h33, 1);
`ifdef UART_RX_FIFO_TIMEOUT_EN
      for (int i = 0; i < 63; i++) begin
         ifc.s_tick = 1; cyc(); ifc.s_tick = 0; cyc();
      end
      chk("t_before", 32'(ifc.rx_timeout), 0);
      ifc.s_tick = 1; cyc(); ifc.s_tick = 0;
      chk("t_hit", 32'(ifc.rx_timeout), 1);
      for (int i = 0; i < 4; i++) begin
         ifc.s_tick = 1; cyc(); ifc.s_tick = 0; cyc();
      end
      chk("t_sat", 32'(ifc.rx_timeout), 1);
      pop();
      chk("t_pop", 32'(ifc.rx_timeout), 0);
`else
      for (int i = 0; i < 70; i++) begin
         ifc.s_tick = 1; cyc(); ifc.s_tick = 0; cyc();
      end
      chk("t_off", 32'(ifc.rx_timeout), 0);
      pop();
`endif

      // Asynchronous reset mid-stream
      push(8'h01, 1); push(8'h02, 1); push(8'h03, 1);
      #2;
      PRESETn = 1'b0;
      sb.delete();
      #1;
      chk("ar_empty", 32'(ifc.empty), 1);
      chk("ar_count", 32'(ifc.count), 0);
      cyc(2);
      PRESETn = 1'b1;
      cyc();
      chk("ar_after", 32'(ifc.empty), 1);

      chk("sb_drained", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
